io_uart: RTL and testbench

- Memory-mapped UART peripheral on the core's io bus (io_write_en/io_read_en/io_address/io_write_data -> io_read_data).
- Sits beside the LED/hex register decode in the FPGA top level and drives the uart_tx/uart_rx board pins.
- Provides a polled transmitter, a receiver with a small RX FIFO, and a status register, so software gets a console without the debug trace path.

---
 rtl/io_uart_pkg.sv | 20 ++
 rtl/io_uart_receive.sv | 101 ++++++++++
 rtl/io_uart.sv | 173 +++++++++++++++++
 tb/tb_io_uart.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_uart_pkg.sv
// Shared constants and state encoding for the io_uart peripheral and its receiver.
package io_uart_pkg;

  localparam logic [31:0] UART_STATUS = 32'd0;
  localparam logic [31:0] UART_RX     = 32'd4;
  localparam logic [31:0] UART_TX     = 32'd8;

  localparam int STAT_RX_READY  = 0;
  localparam int STAT_TX_READY  = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_FRAME_ERR = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/io_uart_receive.sv
// 8N1 serial receiver: two-flop synchroniser, mid-bit sampling FSM, one-cycle result pulses.
//   state | meaning
//   IDLE  | line idle, watching for a falling edge
//   START | counting to mid start bit; high there means a glitch
//   DATA  | sampling 8 data bits LSB first, one per bit period
//   STOP  | sampling the stop bit; on a break, waits for the line to rise
module uart_receive
  import io_uart_pkg::*;
#(
  parameter int BAUD_DIVIDE = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic       rx_valid,
  output logic [7:0] rx_char,
  output logic       frame_err
);

  localparam int CW = $clog2(BAUD_DIVIDE);

  uart_state_t   state;
  logic          rx_meta;
  logic          rx_sync;
  logic          rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          wait_high;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      wait_high <= 1'b0;
      rx_valid  <= 1'b0;
      rx_char   <= '0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= uart_rx;
      rx_sync   <= rx_meta;
      rx_prev   <= rx_sync;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_prev && !rx_sync) begin
            state <= START;
            cnt   <= CW'(BAUD_DIVIDE / 2 - 1);
          end
        end
        START: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (rx_sync) begin
            state <= IDLE;
          end else begin
            state   <= DATA;
            cnt     <= CW'(BAUD_DIVIDE - 1);
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            shift <= {rx_sync, shift[7:1]};
            cnt   <= CW'(BAUD_DIVIDE - 1);
            if (bit_cnt == 3'd7) state <= STOP;
            else bit_cnt <= bit_cnt + 3'd1;
          end
        end
        STOP: begin
          // A low stop bit may be a break; don't rearm until the line is released.
          if (wait_high) begin
            if (rx_sync) begin
              wait_high <= 1'b0;
              state     <= IDLE;
            end
          end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (rx_sync) begin
            rx_valid <= 1'b1;
            rx_char  <= shift;
            state    <= IDLE;
          end else begin
            frame_err <= 1'b1;
            wait_high <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/io_uart.sv
// Memory-mapped UART: status/RX/TX register decode, RX FIFO and polled transmitter.
//   state | meaning
//   IDLE  | transmitter free, tx_ready=1
//   START | driving the start bit
//   DATA  | driving 8 data bits LSB first
//   STOP  | driving the stop bit
module io_uart
  import io_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS  = 32'h18,
  parameter int          BAUD_DIVIDE   = 434,
  parameter int          RX_FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_write_en,
  input  logic        io_read_en,
  input  logic [31:0] io_address,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int CW = $clog2(BAUD_DIVIDE);
  localparam int PW = $clog2(RX_FIFO_DEPTH);

  logic       hit_status;
  logic       hit_rx;
  logic       hit_tx;
  logic       rx_valid;
  logic [7:0] rx_char;
  logic       rx_frame_err;

  assign hit_status = (io_address == BASE_ADDRESS + UART_STATUS);
  assign hit_rx     = (io_address == BASE_ADDRESS + UART_RX);
  assign hit_tx     = (io_address == BASE_ADDRESS + UART_TX);

  uart_receive #(.BAUD_DIVIDE(BAUD_DIVIDE)) u_receive (
    .clk       (clk),
    .reset     (reset),
    .uart_rx   (uart_rx),
    .rx_valid  (rx_valid),
    .rx_char   (rx_char),
    .frame_err (rx_frame_err)
  );

  logic [7:0]    fifo_mem [RX_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          push_ok;
  logic          overrun_set;

  assign fifo_empty  = (fifo_count == '0);
  assign fifo_full   = (fifo_count == (PW+1)'(RX_FIFO_DEPTH));
  assign pop         = io_read_en && hit_rx && !fifo_empty;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign push_ok     = rx_valid && (!fifo_full || pop);
  assign overrun_set = rx_valid && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= rx_char;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  uart_state_t   tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_ready;
  logic          overrun;
  logic          frame_err_flag;
  logic          status_clr;
  logic [31:0]   status_word;

  assign tx_ready   = (tx_state == IDLE);
  assign status_clr = io_read_en && hit_status;

  always_comb begin
    status_word                 = '0;
    status_word[STAT_RX_READY]  = !fifo_empty;
    status_word[STAT_TX_READY]  = tx_ready;
    status_word[STAT_OVERRUN]   = overrun;
    status_word[STAT_FRAME_ERR] = frame_err_flag;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      io_read_data   <= '0;
      overrun        <= 1'b0;
      frame_err_flag <= 1'b0;
    end else begin
      overrun        <= overrun_set  || (overrun && !status_clr);
      frame_err_flag <= rx_frame_err || (frame_err_flag && !status_clr);
      if (io_read_en) begin
        if (hit_status)               io_read_data <= status_word;
        else if (hit_rx && !fifo_empty) io_read_data <= {24'b0, fifo_mem[rd_ptr]};
        else                          io_read_data <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        IDLE: begin
          if (io_write_en && hit_tx) begin
            tx_shift <= io_write_data[7:0];
            tx_cnt   <= CW'(BAUD_DIVIDE - 1);
            uart_tx  <= 1'b0;
            tx_state <= START;
          end
        end
        START: begin
          if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - CW'(1);
          end else begin
            uart_tx  <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= '0;
            tx_cnt   <= CW'(BAUD_DIVIDE - 1);
            tx_state <= DATA;
          end
        end
        DATA: begin
          if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - CW'(1);
          end else if (tx_bit == 3'd7) begin
            uart_tx  <= 1'b1;
            tx_cnt   <= CW'(BAUD_DIVIDE - 1);
            tx_state <= STOP;
          end else begin
            uart_tx  <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= tx_bit + 3'd1;
            tx_cnt   <= CW'(BAUD_DIVIDE - 1);
          end
        end
        STOP: begin
          if (tx_cnt != '0) tx_cnt <= tx_cnt - CW'(1);
          else tx_state <= IDLE;
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart.sv
// Self-checking bench for io_uart with BAUD_DIVIDE=8, RX_FIFO_DEPTH=4, base 'h18.
module tb_io_uart;

  logic        clk;
  logic        reset;
  logic        io_write_en;
  logic        io_read_en;
  logic [31:0] io_address;
  logic [31:0] io_write_data;
  logic [31:0] io_read_data;
  logic        uart_tx;
  logic        uart_rx;

  int errors = 0;
  int checks = 0;
  int model_count = 0;
  logic [7:0] rx_q [$];
  logic [7:0] tx_q [$];

  io_uart #(.BASE_ADDRESS(32'h18), .BAUD_DIVIDE(8), .RX_FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .io_write_en   (io_write_en),
    .io_read_en    (io_read_en),
    .io_address    (io_address),
    .io_write_data (io_write_data),
    .io_read_data  (io_read_data),
    .uart_tx       (uart_tx),
    .uart_rx       (uart_rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic io_read(input logic [31:0] addr, output logic [31:0] data);
    @(posedge clk); #1;
    io_read_en = 1'b1;
    io_address = addr;
    @(posedge clk); #1;
    io_read_en = 1'b0;
    data = io_read_data;
  endtask

  task automatic io_write(input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    io_write_en   = 1'b1;
    io_address    = addr;
    io_write_data = data;
    @(posedge clk); #1;
    io_write_en = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, data, 1'b0};
    if (stop_bit) begin
      if (model_count < 4) begin
        rx_q.push_back(data);
        model_count++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      uart_rx = frame[i];
      repeat (7) @(posedge clk);
    end
    @(posedge clk); #1;
    uart_rx = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic read_rx_check(input string name);
    logic [31:0] got;
    logic [31:0] exp;
    exp = 32'h0;
    if (rx_q.size() > 0) begin
      exp = {24'b0, rx_q.pop_front()};
      model_count--;
    end
    io_read(32'h1C, got);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    logic [31:0] st;
    reset = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++;
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
    checks++;
    if (io_read_data !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", io_read_data); end
    reset = 1'b1;
    io_read(32'h18, st);
    checks++;
    if (st !== 32'h2) begin errors++; $display("FAIL reset_status: got %h expected 2", st); end
    checks++;
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx_idle: got %b expected 1", uart_tx); end
  endtask

  task automatic test_tx();
    logic [9:0]  frame;
    logic [7:0]  got;
    logic [7:0]  exp;
    logic [31:0] st;
    logic [31:0] st_busy;
    int bad;
    frame = {1'b1, 8'hA5, 1'b0};
    @(posedge clk); #1;
    io_write_en   = 1'b1;
    io_address    = 32'h20;
    io_write_data = 32'h1A5;
    tx_q.push_back(8'hA5);
    @(posedge clk); #1;
    io_write_en = 1'b0;
    bad = 0;
    got = '0;
    st_busy = 32'hFFFF_FFFF;
    for (int k = 0; k < 80; k++) begin
      if (uart_tx !== frame[k/8]) bad++;
      if ((k % 8) == 4 && (k / 8) >= 1 && (k / 8) <= 8) got[(k/8)-1] = uart_tx;
      if (k == 20) begin io_read_en = 1'b1; io_address = 32'h18; end
      if (k == 21) begin io_read_en = 1'b0; st_busy = io_read_data; end
      if (k == 40) begin io_write_en = 1'b1; io_address = 32'h20; io_write_data = 32'h0FF; end
      if (k == 41) io_write_en = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL tx_waveform: %0d bad cycles expected 0", bad); end
    checks++;
    if (tx_q.size() == 0) begin
      errors++; $display("FAIL tx_scoreboard: queue empty expected one entry");
    end else begin
      exp = tx_q.pop_front();
      if (got !== exp) begin errors++; $display("FAIL tx_byte: got %h expected %h", got, exp); end
    end
    checks++;
    if (st_busy !== 32'h0) begin errors++; $display("FAIL tx_busy_status: got %h expected 0", st_busy); end
    io_read(32'h18, st);
    checks++;
    if (st !== 32'h2) begin errors++; $display("FAIL tx_done_status: got %h expected 2", st); end
    bad = 0;
    repeat (100) begin
      if (uart_tx !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL tx_no_extra_frame: %0d low cycles expected 0", bad); end
  endtask

  task automatic test_rx_single();
    logic [31:0] st;
    send_frame(8'h3C, 1'b1);
    io_read(32'h18, st);
    checks++;
    if (st !== 32'h3) begin errors++; $display("FAIL rx_ready_status: got %h expected 3", st); end
    read_rx_check("rx_single_data");
    io_read(32'h18, st);
    checks++;
    if (st !== 32'h2) begin errors++; $display("FAIL rx_drained_status: got %h expected 2", st); end
  endtask

  task automatic test_overrun();
    logic [31:0] st;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1);
      repeat (2) @(posedge clk);
    end
    io_read(32'h18, st);
    checks++;
    if (st !== 32'h7) begin errors++; $display("FAIL overrun_status: got %h expected 7", st); end
    for (int i = 0; i < 4; i++) read_rx_check("overrun_data");
    io_read(32'h18, st);
    checks++;
    if (st !== 32'h2) begin errors++; $display("FAIL overrun_cleared: got %h expected 2", st); end
    read_rx_check("empty_rx_read");
  endtask

  task automatic test_frame_err();
    logic [31:0] st;
    send_frame(8'h55, 1'b0);
    repeat (4) @(posedge clk);
    io_read(32'h18, st);
    checks++;
    if (st !== 32'hA) begin errors++; $display("FAIL frame_err_status: got %h expected a", st); end
    read_rx_check("frame_err_no_push");
    io_read(32'h18, st);
    checks++;
    if (st !== 32'h2) begin errors++; $display("FAIL frame_err_cleared: got %h expected 2", st); end
  endtask

  task automatic test_glitch();
    logic [31:0] st;
    @(posedge clk); #1;
    uart_rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (30) @(posedge clk);
    io_read(32'h18, st);
    checks++;
    if (st !== 32'h2) begin errors++; $display("FAIL glitch_status: got %h expected 2", st); end
  endtask

  task automatic test_unmapped();
    logic [31:0] st;
    io_write(32'h18, 32'hFFFF_FFFF);
    io_read(32'h24, st);
    checks++;
    if (st !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h expected 0", st); end
    io_read(32'h18, st);
    checks++;
    if (st !== 32'h2) begin errors++; $display("FAIL status_write_ignored: got %h expected 2", st); end
  endtask

  task automatic test_reset_mid_tx();
    logic [31:0] st;
    io_write(32'h20, 32'h5A);
    repeat (30) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_mid_tx: got %b expected 1", uart_tx); end
    checks++;
    if (io_read_data !== 32'h0) begin errors++; $display("FAIL reset_mid_rdata: got %h expected 0", io_read_data); end
    @(posedge clk); #1;
    reset = 1'b1;
    io_read(32'h18, st);
    checks++;
    if (st !== 32'h2) begin errors++; $display("FAIL reset_mid_status: got %h expected 2", st); end
  endtask

  initial begin
    reset         = 1'b0;
    io_write_en   = 1'b0;
    io_read_en    = 1'b0;
    io_address    = '0;
    io_write_data = '0;
    uart_rx       = 1'b1;
    test_reset();
    test_tx();
    test_rx_single();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_unmapped();
    test_reset_mid_tx();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
